// File: rtl/serdes_pkg.sv
// Shared types and helpers for the SERDES link-partner transmit stage.
package serdes_pkg;

    typedef enum logic [1:0] {
        OFF,
        DETECT,
        IDLE,
        ACTIVE
    } serdes_tx_state_e;

    localparam int unsigned SERDES_SYM_W_DEFAULT = 10;
    localparam int unsigned SERDES_DATA_MAX      = 1024;
    localparam int unsigned SERDES_SLICE_MAX     = 32;

    // Extract lane's symbol from a flattened lane-major word.
    function automatic logic [SERDES_SLICE_MAX-1:0] sym_slice(
        input logic [SERDES_DATA_MAX-1:0] data,
        input int unsigned                lane,
        input int unsigned                sym_w = SERDES_SYM_W_DEFAULT
    );
        logic [SERDES_DATA_MAX-1:0]  shifted;
        logic [SERDES_SLICE_MAX-1:0] mask;
        shifted = data >> (lane * sym_w);
        mask    = (sym_w >= SERDES_SLICE_MAX) ? '1
                : ((SERDES_SLICE_MAX'(1) << sym_w) - SERDES_SLICE_MAX'(1));
        return shifted[SERDES_SLICE_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/serdes_lane_shifter.sv
// Per-lane symbol shift register driving a registered complementary pair.
module serdes_lane_shifter
    import serdes_pkg::*;
#(
    parameter int unsigned SYM_W = SERDES_SYM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             drive,
    input  logic [SYM_W-1:0] din,
    output logic             rxp,
    output logic             rxn
);

    // Holds the bits still to be sent; bit 0 of a new symbol goes straight out.
    logic [SYM_W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            rxp <= 1'b0;
            rxn <= 1'b0;
        end else if (drive && load) begin
            sr  <= din >> 1;
            rxp <= din[0];
            rxn <= ~din[0];
        end else if (drive && shift) begin
            sr  <= sr >> 1;
            rxp <= sr[0];
            rxn <= ~sr[0];
        end else begin
            rxp <= 1'b0;
            rxn <= 1'b0;
        end
    end

endmodule

// File: rtl/serdes_lane_serializer.sv
// Link-partner transmit stage: serializes lock-stepped lane symbols LSB-first
// with electrical-idle and far-end presence signalling.
module serdes_lane_serializer
    import serdes_pkg::*;
#(
    parameter int unsigned NL          = 1,
    parameter int unsigned SYM_W       = SERDES_SYM_W_DEFAULT,
    parameter int unsigned PRESENT_DLY = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NL*SYM_W-1:0] sym_data,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic                eidle_req,
    output logic [NL-1:0]       rxp,
    output logic [NL-1:0]       rxn,
    output logic [NL-1:0]       rxpresent,
    output logic                underrun
);

    localparam int unsigned       CW       = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam logic [CW-1:0]     BIT_LAST = CW'(SYM_W - 1);
    localparam logic [7:0]        DLY_END  = 8'(PRESENT_DLY);

    serdes_tx_state_e state;
    logic [7:0]       dly_cnt;
    logic [CW-1:0]    bit_cnt;
    logic             accept;
    logic             at_last;
    logic             shift_en;

    always_comb begin
        sym_ready = 1'b0;
        case (state)
            IDLE:    sym_ready = !eidle_req;
            ACTIVE:  sym_ready = (bit_cnt == BIT_LAST) && !eidle_req;
            default: sym_ready = 1'b0;
        endcase
    end

    assign accept   = en && sym_valid && sym_ready;
    assign at_last  = (state == ACTIVE) && (bit_cnt == BIT_LAST);
    assign shift_en = (state == ACTIVE) && !at_last;

    // Counter is compared against PRESENT_DLY (not -1) so rxpresent rises
    // PRESENT_DLY+1 edges after the edge that samples en high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OFF;
            dly_cnt   <= '0;
            bit_cnt   <= '0;
            rxpresent <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (!en) begin
                state     <= OFF;
                dly_cnt   <= '0;
                bit_cnt   <= '0;
                rxpresent <= '0;
            end else begin
                case (state)
                    OFF: begin
                        state   <= DETECT;
                        dly_cnt <= '0;
                    end
                    DETECT: begin
                        if (dly_cnt == DLY_END) begin
                            state     <= IDLE;
                            rxpresent <= '1;
                        end else begin
                            dly_cnt <= dly_cnt + 8'd1;
                        end
                    end
                    IDLE: begin
                        if (accept) begin
                            state   <= ACTIVE;
                            bit_cnt <= '0;
                        end
                    end
                    ACTIVE: begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (!accept) begin
                                state    <= IDLE;
                                underrun <= !eidle_req;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end

    for (genvar l = 0; l < NL; l++) begin : g_lane
        serdes_lane_shifter #(
            .SYM_W(SYM_W)
        ) u_shifter (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept),
            .shift (shift_en),
            .drive (en),
            .din   (SYM_W'(sym_slice(SERDES_DATA_MAX'(sym_data), unsigned'(l), SYM_W))),
            .rxp   (rxp[l]),
            .rxn   (rxn[l])
        );
    end

endmodule

// File: tb/tb_serdes_lane_serializer.sv
// Self-checking bench for serdes_lane_serializer (NL=4, SYM_W=10, PRESENT_DLY=16).
`timescale 1ns/1ps
module tb_serdes_lane_serializer;

    localparam int unsigned NL  = 4;
    localparam int unsigned SW  = 10;
    localparam int unsigned DLY = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [NL*SW-1:0] sym_data = '0;
    logic             sym_valid = 1'b0;
    logic             eidle_req = 1'b0;
    logic             sym_ready;
    logic [NL-1:0]    rxp;
    logic [NL-1:0]    rxn;
    logic [NL-1:0]    rxpresent;
    logic             underrun;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    serdes_lane_serializer #(
        .NL          (NL),
        .SYM_W       (SW),
        .PRESENT_DLY (DLY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .eidle_req (eidle_req),
        .rxp       (rxp),
        .rxn       (rxn),
        .rxpresent (rxpresent),
        .underrun  (underrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per expected serial bit (all lanes), pushed on accept.
    typedef struct {
        logic [NL-1:0] p;
        bit            last;
    } bit_t;

    bit_t        sbq[$];
    bit          prev_en   = 1'b0;
    int unsigned run       = 0;
    bit          exp_under = 1'b0;

    always @(negedge clk) begin : monitor
        bit_t          cur;
        bit_t          nb;
        bit            have;
        bit            en_s;
        bit            exp_pres;
        bit            exp_rdy;
        bit            acc;
        logic [NL-1:0] e_p;
        logic [NL-1:0] e_n;
        logic [NL-1:0] e_pr;
        have = 1'b0;
        if (!rst_n) begin
            prev_en   = 1'b0;
            exp_under = 1'b0;
            en_s      = 1'b0;
        end else begin
            en_s    = prev_en;
            prev_en = en;
        end
        if (!en_s) begin
            sbq.delete();
            run = 0;
        end else if (run < 1000) begin
            run++;
        end
        exp_pres = (run >= DLY + 2);
        if (sbq.size() > 0) begin
            cur  = sbq.pop_front();
            have = 1'b1;
        end
        e_p  = have ? cur.p : '0;
        e_n  = have ? ~cur.p : '0;
        e_pr = {NL{exp_pres}};
        exp_rdy = exp_pres && !eidle_req && (!have || cur.last);
        chk("rxp", rxp, e_p);
        chk("rxn", rxn, e_n);
        chk("rxpresent", rxpresent, e_pr);
        chk("sym_ready", sym_ready, exp_rdy);
        chk("underrun", underrun, exp_under);
        acc = rst_n && en && sym_valid && exp_rdy;
        if (acc) begin
            for (int k = 0; k < SW; k++) begin
                for (int l = 0; l < NL; l++) nb.p[l] = sym_data[l*SW + k];
                nb.last = (k == SW - 1);
                sbq.push_back(nb);
            end
        end
        exp_under = have && cur.last && !acc && !eidle_req && en && rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a symbol and return 1ns after the accepting edge (bit 0 then on the wire).
    task automatic send(input logic [NL*SW-1:0] d, input bit keep_valid);
        bit ok;
        ok = 1'b0;
        sym_data  = d;
        sym_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sym_ready) ok = 1'b1;
            tick();
        end
        chk("send_accepted", {31'd0, ok}, 32'd1);
        if (!keep_valid) sym_valid = 1'b0;
    endtask

    // Called 1ns after an edge; en is sampled at the following edge E.
    task automatic presence_seq(input string tag);
        logic [NL-1:0] e;
        en = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= DLY + 1; j++) begin
            @(negedge clk);
            e = (j >= DLY + 1) ? '1 : '0;
            chk({tag, "_present"}, rxpresent, e);
            chk({tag, "_rxp"}, rxp, 0);
            chk({tag, "_rxn"}, rxn, 0);
        end
        tick();
    endtask

    typedef struct {
        logic [NL*SW-1:0] data;
        logic [0:SW-1]    seq0;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // seq0 is written in wire order: leftmost character is the first bit sent.
        tbl[0] = '{data: {10'h000, 10'h000, 10'h000, 10'h17C}, seq0: 10'b0011111010};
        tbl[1] = '{data: {10'h155, 10'h2AA, 10'h0F0, 10'h283}, seq0: 10'b1100000101};
        tbl[2] = '{data: {10'h001, 10'h200, 10'h111, 10'h3FF}, seq0: 10'b1111111111};
        tbl[3] = '{data: {10'h3FF, 10'h000, 10'h0AB, 10'h001}, seq0: 10'b1000000000};
        tbl[4] = '{data: {10'h123, 10'h321, 10'h1F0, 10'h200}, seq0: 10'b0000000001};

        #12;
        chk("reset_rxp", rxp, 0);
        chk("reset_rxn", rxn, 0);
        chk("reset_present", rxpresent, 0);
        chk("reset_ready", sym_ready, 0);
        chk("reset_underrun", underrun, 0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        presence_seq("init");

        for (int v = 0; v < 5; v++) begin
            send(tbl[v].data, 1'b0);
            for (int k = 0; k < SW; k++) begin
                @(negedge clk);
                chk("tbl_rxp0", rxp[0], tbl[v].seq0[k]);
                chk("tbl_rxn0", rxn[0], !tbl[v].seq0[k]);
            end
            @(negedge clk);
            chk("tbl_idle_rxp", rxp, 0);
            chk("tbl_idle_rxn", rxn, 0);
            chk("tbl_underrun", underrun, 1);
            @(negedge clk);
            chk("tbl_underrun_pulse", underrun, 0);
            tick();
        end

        // Three back-to-back symbols, valid held high.
        send({10'h2F0, 10'h0F1, 10'h3A5, 10'h15A}, 1'b1);
        send({10'h00F, 10'h3C0, 10'h19B, 10'h2E6}, 1'b1);
        send({10'h1C7, 10'h238, 10'h0D2, 10'h32D}, 1'b0);
        repeat (12) tick();

        // Electrical idle requested mid-symbol with a successor waiting.
        send({10'h0C3, 10'h1E1, 10'h2D2, 10'h3B4}, 1'b0);
        repeat (4) tick();
        eidle_req = 1'b1;
        sym_valid = 1'b1;
        sym_data  = {10'h111, 10'h222, 10'h333, 10'h0AA};
        for (int k = 4; k < SW; k++) begin
            @(negedge clk);
            chk("eidle_ready", sym_ready, 0);
        end
        @(negedge clk);
        chk("eidle_underrun", underrun, 0);
        chk("eidle_rxp", rxp, 0);
        chk("eidle_present", rxpresent, 32'hF);
        chk("eidle_ready_idle", sym_ready, 0);
        tick();
        eidle_req = 1'b0;
        sym_valid = 1'b0;
        repeat (3) tick();

        // Enable dropped at bit 5.
        send({10'h3E7, 10'h18C, 10'h2B5, 10'h1FF}, 1'b0);
        repeat (5) tick();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_present", rxpresent, 0);
        chk("abort_rxp", rxp, 0);
        chk("abort_rxn", rxn, 0);
        chk("abort_underrun", underrun, 0);
        @(negedge clk);
        chk("abort_underrun2", underrun, 0);
        tick();
        presence_seq("reen");

        // Asynchronous reset mid-symbol.
        send({10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rxp", rxp, 0);
        chk("arst_rxn", rxn, 0);
        chk("arst_present", rxpresent, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_ready", sym_ready, 0);
        en = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_ready", sym_ready, 0);
            chk("post_rst_present", rxpresent, 0);
        end
        tick();
        presence_seq("post_rst");
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
